// File: rtl/seq_mul_32_if.sv
// Bundle between the sequential multiplier, its controller and the shared 32-bit adder.
// The slave modport is the multiplier; the master side is the controller plus the external adder.
interface seq_mul_32_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic               add_sub;
  logic [WIDTH-1:0]   add_s;
  logic               add_cout;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport slave (
    input  start, mcand, mplier, add_s, add_cout,
    output add_a, add_b, add_sub, busy, done, product
  );

  modport master (
    output start, mcand, mplier, add_s, add_cout,
    input  add_a, add_b, add_sub, busy, done, product
  );
endinterface

// File: rtl/seq_mul_32.sv
// 32x32->64 shift-and-add multiplier that borrows the external ripple adder each iteration.
// Define SEQ_MUL_BOOTH_SIGNED_EN for a two's-complement radix-2 Booth build.
module seq_mul_32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic        clk,
  input logic        rst,
  seq_mul_32_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  state_t             state_nx;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   p_hi;
  logic [WIDTH-1:0]   p_lo;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] product_q;
  logic [2*WIDTH-1:0] acc_nx;
  logic               accept;
  logic               last_iter;

  assign accept    = (state != RUN) && bus.start;
  assign last_iter = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

  // Adder operands come only from registers so the adder loop is broken here.
  assign bus.add_a   = p_hi;
  assign bus.add_b   = m;
  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == DONE);
  assign bus.product = product_q;

`ifdef SEQ_MUL_BOOTH_SIGNED_EN
  logic             q_1;
  logic             do_op;
  logic             ovf;
  logic             sb;
  logic [WIDTH-1:0] r;

  assign bus.add_sub = p_lo[0] & ~q_1;
  assign do_op       = p_lo[0] ^ q_1;
  assign r           = do_op ? bus.add_s : p_hi;
  // On signed overflow the adder's sign bit is wrong, so the true sign is its complement.
  assign ovf = do_op
             && (bus.add_a[WIDTH-1] == (bus.add_b[WIDTH-1] ^ bus.add_sub))
             && (bus.add_s[WIDTH-1] != bus.add_a[WIDTH-1]);
  assign sb     = r[WIDTH-1] ^ ovf;
  assign acc_nx = {sb, r, p_lo[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      q_1 <= 1'b0;
    end else if (accept) begin
      q_1 <= 1'b0;
    end else if (state == RUN) begin
      q_1 <= p_lo[0];
    end
  end
`else
  assign bus.add_sub = 1'b0;
  assign acc_nx = p_lo[0] ? {bus.add_cout, bus.add_s, p_lo[WIDTH-1:1]}
                          : {1'b0, p_hi, p_lo[WIDTH-1:1]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_nx = DONE;
      DONE:    state_nx = bus.start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The product register only updates on the final iteration, so it holds across idle time.
  always_ff @(posedge clk) begin
    if (rst) begin
      m         <= '0;
      p_hi      <= '0;
      p_lo      <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else if (accept) begin
      m    <= bus.mcand;
      p_lo <= bus.mplier;
      p_hi <= '0;
      cnt  <= '0;
    end else if (state == RUN) begin
      {p_hi, p_lo} <= acc_nx;
      cnt          <= cnt + CNT_W'(1);
      if (last_iter) begin
        product_q <= acc_nx;
      end
    end
  end
endmodule

// File: tb/tb_seq_mul_32.sv
// Directed self-checking bench for seq_mul_32; models the external ripple adder behaviourally.
// Expected products follow the build: unsigned by default, signed when SEQ_MUL_BOOTH_SIGNED_EN is set.
module tb_seq_mul_32;
  logic clk;
  logic rst;
  int   tests;
  int   failed;
  logic sub_seen;

  seq_mul_32_if #(.WIDTH(32)) bus ();

  seq_mul_32 u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign {bus.add_cout, bus.add_s} = bus.add_sub
      ? ({1'b0, bus.add_a} + {1'b0, ~bus.add_b} + 33'd1)
      : ({1'b0, bus.add_a} + {1'b0, bus.add_b});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.add_sub === 1'b1) sub_seen = 1'b1;
  end

`ifdef SEQ_MUL_BOOTH_SIGNED_EN
  localparam logic [63:0] EXP_FF  = 64'h0000000000000001;
  localparam logic [63:0] EXP_FD5 = 64'hFFFFFFFFFFFFFFF1;
  localparam logic [63:0] EXP_81  = 64'hFFFFFFFF80000000;
`else
  localparam logic [63:0] EXP_FF  = 64'hFFFFFFFE00000001;
  localparam logic [63:0] EXP_FD5 = 64'h00000004FFFFFFF1;
  localparam logic [63:0] EXP_81  = 64'h0000000080000000;
`endif

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic s, input logic [31:0] a, input logic [31:0] b);
    bus.start  = s;
    bus.mcand  = a;
    bus.mplier = b;
  endtask

  // Called right after the start-sample edge; returns how many edges later done appeared.
  task automatic wait_done(input string tag, input logic [31:0] m_exp, output int cycles);
    int busy_low;
    int addb_bad;
    cycles   = 0;
    busy_low = 0;
    addb_bad = 0;
    while (bus.done !== 1'b1 && cycles < 40) begin
      if (bus.busy !== 1'b1) busy_low++;
      if (bus.add_b !== m_exp) addb_bad++;
      @(negedge clk);
      cycles++;
    end
    check_output({tag, "_busy_gaps"}, 64'(busy_low), 64'd0);
    check_output({tag, "_add_b_bad"}, 64'(addb_bad), 64'd0);
    check_output({tag, "_cycles"}, 64'(cycles), 64'd32);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    int cycles;
    apply_stimulus(1'b1, a, b);
    @(negedge clk);
    apply_stimulus(1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A);
    wait_done(tag, a, cycles);
    check_output({tag, "_product"}, bus.product, exp);
    check_output({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    @(negedge clk);
    check_output({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    check_output({tag, "_product_hold"}, bus.product, exp);
  endtask

  initial begin
    int  cycles;
    logic done_seen;
    tests    = 0;
    failed   = 0;
    sub_seen = 1'b0;
    rst      = 1'b1;
    apply_stimulus(1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    check_output("reset_busy", 64'(bus.busy), 64'd0);
    check_output("reset_done", 64'(bus.done), 64'd0);
    check_output("reset_product", bus.product, 64'd0);
    check_output("reset_add_a", 64'(bus.add_a), 64'd0);
    check_output("reset_add_b", 64'(bus.add_b), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mul_7x6", 32'd7, 32'd6, 64'h000000000000002A);
    run_op("mul_ffxff", 32'hFFFFFFFF, 32'hFFFFFFFF, EXP_FF);
    run_op("mul_0xdead", 32'h00000000, 32'hDEADBEEF, 64'd0);
    run_op("mul_8x8", 32'h80000000, 32'h80000000, 64'h4000000000000000);
    run_op("mul_fdx5", 32'hFFFFFFFD, 32'd5, EXP_FD5);
    run_op("mul_8x1", 32'h80000000, 32'd1, EXP_81);

    // Start during RUN is ignored; start held through DONE restarts with the held operands.
    apply_stimulus(1'b1, 32'd3, 32'd5);
    @(negedge clk);
    apply_stimulus(1'b0, 32'd0, 32'd0);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 9) apply_stimulus(1'b1, 32'd9, 32'd9);
      if (k == 20) check_output("ignore_add_b", 64'(bus.add_b), 64'd3);
    end
    check_output("b2b_done1", 64'(bus.done), 64'd1);
    check_output("b2b_product1", bus.product, 64'h000000000000000F);
    @(negedge clk);
    check_output("b2b_restart_busy", 64'(bus.busy), 64'd1);
    check_output("b2b_restart_done", 64'(bus.done), 64'd0);
    check_output("b2b_product_held", bus.product, 64'h000000000000000F);
    apply_stimulus(1'b0, 32'd0, 32'd0);
    wait_done("b2b_op2", 32'd9, cycles);
    check_output("b2b_product2", bus.product, 64'h0000000000000051);
    @(negedge clk);
    check_output("b2b_done2_pulse", 64'(bus.done), 64'd0);

    // Reset lands on edge 15 of a multiply.
    apply_stimulus(1'b1, 32'h12345678, 32'h9ABCDEF0);
    @(negedge clk);
    apply_stimulus(1'b0, 32'd0, 32'd0);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("abort_busy", 64'(bus.busy), 64'd0);
    check_output("abort_done", 64'(bus.done), 64'd0);
    check_output("abort_product", bus.product, 64'd0);
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen = 1'b1;
    end
    check_output("abort_no_done", 64'(done_seen), 64'd0);
    check_output("abort_idle_busy", 64'(bus.busy), 64'd0);

`ifdef SEQ_MUL_BOOTH_SIGNED_EN
    check_output("booth_sub_used", 64'(sub_seen), 64'd1);
`else
    check_output("unsigned_sub_never", 64'(sub_seen), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
